// File: rtl/audio_pkg.sv
// Shared types and widths for the audio envelope/PWM output stage.
package audio_pkg;

    localparam int ENV_W = 4;
    localparam int PWM_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } env_state_t;

    // One saturating step of the envelope level toward target (holds when equal).
    function automatic logic [ENV_W-1:0] step_toward(input logic [ENV_W-1:0] level,
                                                     input logic [ENV_W-1:0] target);
        logic [ENV_W-1:0] result;
        if (level < target) begin
            result = level + 4'd1;
        end else if (level > target) begin
            result = level - 4'd1;
        end else begin
            result = level;
        end
        return result;
    endfunction

endpackage

// File: rtl/env_step_timer.sv
// Envelope step timer: counts 0..ENV_STEP_CYCLES-1 and pulses step at the terminal count.
module env_step_timer #(
    parameter int ENV_STEP_CYCLES = 100_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic step
);

    localparam int CNT_W = (ENV_STEP_CYCLES > 1) ? $clog2(ENV_STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(ENV_STEP_CYCLES - 1);

    logic [CNT_W-1:0] cnt_r;

    assign step = (cnt_r == TERM);

    // Step counter; clear wins so a new state always starts a full interval.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clear || step) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/audio_envelope_pwm.sv
// Tone output stage: ASR envelope gating plus PWM loudness scaling of the square wave.
module audio_envelope_pwm
    import audio_pkg::*;
#(
    parameter int CLK_HZ          = 100_000_000,
    parameter int ENV_STEP_CYCLES = 100_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tone_in,
    input  logic             gate,
    input  logic [ENV_W-1:0] volume,
    input  logic             mute,
    output logic             audio_out,
    output logic [ENV_W-1:0] env_level,
    output logic             busy
);

    env_state_t       state_r;
    env_state_t       state_nxt_s;
    logic [ENV_W-1:0] level_r;
    logic [ENV_W-1:0] level_nxt_s;
    logic [PWM_W-1:0] pwm_cnt_r;
    logic             tone_q_r;
    logic             audio_r;
    logic             busy_r;
    logic             step_s;
    logic             clear_s;

    // Timer restarts on every state change so each state gets full-length steps.
    assign clear_s = mute | (state_nxt_s != state_r);

    env_step_timer #(
        .ENV_STEP_CYCLES(ENV_STEP_CYCLES)
    ) u_step_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(clear_s),
        .step (step_s)
    );

    // Envelope next-state and next-level logic; mute overrides every state.
    always_comb begin
        state_nxt_s = state_r;
        level_nxt_s = level_r;
        if (mute) begin
            state_nxt_s = IDLE;
            level_nxt_s = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (gate && (volume != 4'd0)) begin
                        state_nxt_s = ATTACK;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                ATTACK: begin
                    if (!gate) begin
                        state_nxt_s = RELEASE;
                    end else if (level_r >= volume) begin
                        state_nxt_s = SUSTAIN;
                    end else if (step_s) begin
                        level_nxt_s = step_toward(level_r, volume);
                    end else begin
                        level_nxt_s = level_r;
                    end
                end
                SUSTAIN: begin
                    if (!gate) begin
                        state_nxt_s = RELEASE;
                    end else if (step_s) begin
                        level_nxt_s = step_toward(level_r, volume);
                    end else begin
                        level_nxt_s = level_r;
                    end
                end
                RELEASE: begin
                    // Retrigger resumes from the current level rather than from 0.
                    if (gate && (volume != 4'd0)) begin
                        state_nxt_s = ATTACK;
                    end else if (level_r == 4'd0) begin
                        state_nxt_s = IDLE;
                    end else if (step_s) begin
                        level_nxt_s = step_toward(level_r, 4'd0);
                    end else begin
                        level_nxt_s = level_r;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    level_nxt_s = '0;
                end
            endcase
        end
    end

    // Envelope state, level and busy flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            level_r <= '0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            level_r <= level_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
        end
    end

    // Tone input register, free-running PWM carrier and registered output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tone_q_r  <= 1'b0;
            pwm_cnt_r <= '0;
            audio_r   <= 1'b0;
        end else begin
            tone_q_r  <= tone_in;
            pwm_cnt_r <= pwm_cnt_r + 4'd1;
            audio_r   <= tone_q_r & (pwm_cnt_r < level_r) & ~mute;
        end
    end

    assign audio_out = audio_r;
    assign env_level = level_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_audio_envelope_pwm.sv
// Scoreboard bench for audio_envelope_pwm: directed scenarios plus random segments vs a reference model.
module tb_audio_envelope_pwm;

    localparam int N         = 4;
    localparam int M_IDLE    = 0;
    localparam int M_ATTACK  = 1;
    localparam int M_SUSTAIN = 2;
    localparam int M_RELEASE = 3;

    typedef struct {
        logic       audio;
        logic [3:0] level;
        logic       busy;
    } exp_t;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       tone_in = 1'b0;
    logic       gate    = 1'b0;
    logic       mute    = 1'b0;
    logic [3:0] volume  = 4'd0;
    logic       audio_out;
    logic [3:0] env_level;
    logic       busy;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t exp_q[$];
    bit   started = 1'b0;
    bit   done    = 1'b0;
    int   cyc     = 0;

    // Reference model state: phase, level, cycles spent in phase, carrier position, delayed tone.
    int m_phase = M_IDLE;
    int m_level = 0;
    int m_age   = 0;
    int m_pwm   = 0;
    bit m_tone_q = 1'b0;

    audio_envelope_pwm #(
        .CLK_HZ         (100_000_000),
        .ENV_STEP_CYCLES(N)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tone_in  (tone_in),
        .gate     (gate),
        .volume   (volume),
        .mute     (mute),
        .audio_out(audio_out),
        .env_level(env_level),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // One clock edge of the envelope/PWM behaviour, computed from the rules directly.
    task automatic model_edge(input bit r, input bit t, input bit g, input logic [3:0] v,
                              input bit m, output exp_t e);
        int  np;
        int  nl;
        bit  step;
        int  vi;
        vi = int'(v);
        if (r) begin
            m_phase = M_IDLE; m_level = 0; m_age = 0; m_pwm = 0; m_tone_q = 1'b0;
            e.audio = 1'b0; e.level = 4'd0; e.busy = 1'b0;
        end else begin
            e.audio = m_tone_q && (m_pwm < m_level) && !m;
            step = ((m_age % N) == N - 1);
            np = m_phase;
            nl = m_level;
            if (m) begin
                np = M_IDLE; nl = 0;
            end else if (m_phase == M_IDLE) begin
                if (g && vi != 0) np = M_ATTACK;
            end else if (m_phase == M_ATTACK) begin
                if (!g) np = M_RELEASE;
                else if (m_level >= vi) np = M_SUSTAIN;
                else if (step) nl = (m_level < 15) ? m_level + 1 : 15;
            end else if (m_phase == M_SUSTAIN) begin
                if (!g) np = M_RELEASE;
                else if (step) nl = m_level + int'(vi > m_level) - int'(vi < m_level);
            end else begin
                if (g && vi != 0) np = M_ATTACK;
                else if (m_level == 0) np = M_IDLE;
                else if (step) nl = (m_level > 0) ? m_level - 1 : 0;
            end
            m_age    = (m || np != m_phase) ? 0 : m_age + 1;
            m_phase  = np;
            m_level  = nl;
            m_tone_q = t;
            m_pwm    = (m_pwm + 1) % 16;
            e.level  = 4'(m_level);
            e.busy   = (m_phase != M_IDLE);
        end
    endtask

    task automatic apply(input bit r, input bit t, input bit g, input logic [3:0] v, input bit m);
        exp_t e;
        @(negedge clk);
        rst = r; tone_in = t; gate = g; volume = v; mute = m;
        if (r) begin
            #1;
            check("async_rst_audio", int'(audio_out), 0);
            check("async_rst_level", int'(env_level), 0);
            check("async_rst_busy", int'(busy), 0);
        end
        model_edge(r, t, g, v, m, e);
        exp_q.push_back(e);
        started = 1'b1;
        cyc++;
    endtask

    // Directed segment with the tone toggling every 8 cycles.
    task automatic seg(input int len, input bit g, input logic [3:0] v, input bit m);
        for (int i = 0; i < len; i++) begin
            apply(1'b0, ((cyc / 8) % 2) == 1, g, v, m);
        end
    endtask

    // Monitor: compare every presented output cycle against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("audio_out", int'(audio_out), int'(e.audio));
                check("env_level", int'(env_level), int'(e.level));
                check("busy", int'(busy), int'(e.busy));
            end else if (started && !done) begin
                vectors++;
                miscompares++;
                $display("FAIL scoreboard_empty: got no expectation, expected one at %0t", $time);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  dur;
        bit  g;
        bit  m;
        bit  r;
        logic [3:0] v;

        apply(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        apply(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);

        seg(30, 1'b1, 4'd3, 1'b0);
        seg(25, 1'b0, 4'd3, 1'b0);
        seg(30, 1'b1, 4'd5, 1'b0);
        seg(13, 1'b0, 4'd5, 1'b0);
        seg(20, 1'b1, 4'd5, 1'b0);
        seg(50, 1'b1, 4'd10, 1'b0);
        seg(20, 1'b1, 4'd7, 1'b0);
        seg(35, 1'b1, 4'd12, 1'b0);
        seg(2, 1'b1, 4'd12, 1'b1);
        seg(20, 1'b1, 4'd12, 1'b0);
        seg(60, 1'b0, 4'd0, 1'b0);
        seg(20, 1'b1, 4'd0, 1'b0);
        seg(10, 1'b1, 4'd9, 1'b0);
        apply(1'b1, 1'b1, 1'b1, 4'd9, 1'b0);
        seg(20, 1'b1, 4'd9, 1'b0);

        repeat (60) begin
            dur = $urandom_range(1, 40);
            g   = ($urandom_range(0, 3) != 0);
            v   = 4'($urandom_range(0, 15));
            m   = ($urandom_range(0, 12) == 0);
            r   = ($urandom_range(0, 25) == 0);
            for (int i = 0; i < dur; i++) begin
                apply(r && (i == 0), $urandom_range(0, 1) == 1, g, v, m && (i < 3));
            end
        end

        @(posedge clk);
        #3;
        done = 1'b1;
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
